// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the RV32I lab CPU control unit: opcodes, ALU controls,
// immediate-select and writeback-select values, and the ALU op classes.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  typedef enum logic [1:0] {
    AOP_ADD = 2'b00,
    AOP_SUB = 2'b01,
    AOP_FR  = 2'b10,
    AOP_FI  = 2'b11
  } alu_op_e;

endpackage

// File: rtl/cpu_alu_decode.sv
// Maps an ALU op class plus Fun3/Fun7 to ALU_Control; funct_ok drops low for
// funct combinations this CPU does not implement (SLL, SRA, SLTU, ...).
module cpu_alu_decode
  import cpu_ctrl_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [2:0] fun3,
  input  logic       fun7,
  output logic [2:0] alu_ctrl,
  output logic       funct_ok
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    funct_ok = 1'b1;
    case (alu_op)
      AOP_ADD: alu_ctrl = ALU_ADD;
      AOP_SUB: alu_ctrl = ALU_SUB;
      default: begin
        case (fun3)
          3'b000: alu_ctrl = (alu_op == AOP_FR && fun7) ? ALU_SUB : ALU_ADD;
          3'b111: alu_ctrl = ALU_AND;
          3'b110: alu_ctrl = ALU_OR;
          3'b100: alu_ctrl = ALU_XOR;
          3'b010: alu_ctrl = ALU_SLT;
          3'b101: begin
            if (fun7) funct_ok = 1'b0;
            else      alu_ctrl = ALU_SRL;
          end
          default: funct_ok = 1'b0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Single-cycle RV32I main decoder with MIO ready qualification; decode is purely combinational.
// Optional memory-wait watchdog (sticky MIO_timeout) enabled by CPU_CTRL_MIO_TIMEOUT_EN.
module cpu_control
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] OPcode,
  input  logic [2:0] Fun3,
  input  logic       Fun7,
  input  logic       MIO_ready,
  output logic [1:0] ImmSel,
  output logic       ALUSrc_B,
  output logic [1:0] MemtoReg,
  output logic       Jump,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemRW,
  output logic [2:0] ALU_Control,
  output logic       CPU_MIO,
  output logic       Stall,
  output logic       MIO_timeout
);

  alu_op_e    alu_op;
  logic [2:0] alu_dec;
  logic       funct_ok;
  logic       reg_write_raw;
  logic       mem_rw_raw;
  logic       cpu_mio_raw;
  logic       is_load;

  always_comb begin
    case (OPcode)
      OP_R:      alu_op = AOP_FR;
      OP_IMM:    alu_op = AOP_FI;
      OP_BRANCH: alu_op = AOP_SUB;
      default:   alu_op = AOP_ADD;
    endcase
  end

  cpu_alu_decode u_alu_decode (
    .alu_op   (alu_op),
    .fun3     (Fun3),
    .fun7     (Fun7),
    .alu_ctrl (alu_dec),
    .funct_ok (funct_ok)
  );

  always_comb begin
    ImmSel        = IMM_I;
    ALUSrc_B      = 1'b0;
    MemtoReg      = MTR_ALU;
    Jump          = 1'b0;
    Branch        = 1'b0;
    ALU_Control   = ALU_ADD;
    reg_write_raw = 1'b0;
    mem_rw_raw    = 1'b0;
    cpu_mio_raw   = 1'b0;
    is_load       = 1'b0;
    case (OPcode)
      OP_R: begin
        if (funct_ok) begin
          reg_write_raw = 1'b1;
          ALU_Control   = alu_dec;
        end
      end
      OP_IMM: begin
        if (funct_ok) begin
          ALUSrc_B      = 1'b1;
          reg_write_raw = 1'b1;
          ALU_Control   = alu_dec;
        end
      end
      OP_LOAD: begin
        ALUSrc_B      = 1'b1;
        MemtoReg      = MTR_MEM;
        reg_write_raw = 1'b1;
        cpu_mio_raw   = 1'b1;
        is_load       = 1'b1;
      end
      OP_STORE: begin
        ImmSel      = IMM_S;
        ALUSrc_B    = 1'b1;
        mem_rw_raw  = 1'b1;
        cpu_mio_raw = 1'b1;
      end
      OP_BRANCH: begin
        if (Fun3 == 3'b000) begin
          ImmSel      = IMM_B;
          Branch      = 1'b1;
          ALU_Control = alu_dec;
        end
      end
      // JAL does not use the ALU, so its control is left at all-zero
      OP_JAL: begin
        ImmSel        = IMM_J;
        Jump          = 1'b1;
        reg_write_raw = 1'b1;
        MemtoReg      = MTR_PC4;
        ALU_Control   = ALU_AND;
      end
      default: ;
    endcase
  end

  // Loads may only write back, and stores only commit, once the bus is ready
  assign RegWrite = reg_write_raw & ~rst & (~is_load | MIO_ready);
  assign MemRW    = mem_rw_raw & ~rst & MIO_ready;
  assign CPU_MIO  = cpu_mio_raw & ~rst;
  assign Stall    = CPU_MIO & ~MIO_ready;

`ifdef CPU_CTRL_MIO_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] wait_cnt;
  logic          timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (Stall) begin
      if (wait_cnt != LIMIT) wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt >= LIMIT - 1'b1) timeout_q <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign MIO_timeout = timeout_q;
`else
  logic unused_wd;
  assign unused_wd   = &{1'b0, clk, (TIMEOUT_CYCLES > 0)};
  assign MIO_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: directed instruction table, random decode
// against an instruction-level model, and watchdog scenarios.
module tb_cpu_control;

  localparam int T = 16;

  typedef struct packed {
    logic [1:0] imm;
    logic       src_b;
    logic [1:0] mtr;
    logic       jump;
    logic       branch;
    logic       reg_write;
    logic       mem_rw;
    logic [2:0] alu;
    logic       mio;
    logic       stall;
  } ctl_t;

  logic       clk;
  logic       rst;
  logic [4:0] OPcode;
  logic [2:0] Fun3;
  logic       Fun7;
  logic       MIO_ready;
  logic [1:0] ImmSel;
  logic       ALUSrc_B;
  logic [1:0] MemtoReg;
  logic       Jump;
  logic       Branch;
  logic       RegWrite;
  logic       MemRW;
  logic [2:0] ALU_Control;
  logic       CPU_MIO;
  logic       Stall;
  logic       MIO_timeout;

  int   n_checks = 0;
  int   n_fails  = 0;
  bit   wd_en;
  logic [31:0] cur_instr;
  bit   cur_ready;
  int   m_cnt;
  bit   m_to;

  cpu_control #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .OPcode      (OPcode),
    .Fun3        (Fun3),
    .Fun7        (Fun7),
    .MIO_ready   (MIO_ready),
    .ImmSel      (ImmSel),
    .ALUSrc_B    (ALUSrc_B),
    .MemtoReg    (MemtoReg),
    .Jump        (Jump),
    .Branch      (Branch),
    .RegWrite    (RegWrite),
    .MemRW       (MemRW),
    .ALU_Control (ALU_Control),
    .CPU_MIO     (CPU_MIO),
    .Stall       (Stall),
    .MIO_timeout (MIO_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t mk(int imm, int src, int mtr, int j, int b, int rw,
                              int mrw, int alu, int mio, int st);
    ctl_t c;
    c.imm = 2'(imm); c.src_b = 1'(src); c.mtr = 2'(mtr); c.jump = 1'(j);
    c.branch = 1'(b); c.reg_write = 1'(rw); c.mem_rw = 1'(mrw);
    c.alu = 3'(alu); c.mio = 1'(mio); c.stall = 1'(st);
    return c;
  endfunction

  function automatic ctl_t observed();
    return {ImmSel, ALUSrc_B, MemtoReg, Jump, Branch, RegWrite, MemRW,
            ALU_Control, CPU_MIO, Stall};
  endfunction

  // Instruction-level reference: classify the mnemonic, then apply the bus rules.
  function automatic ctl_t model(logic [31:0] ins, bit ready, bit r);
    ctl_t c;
    logic [6:0] op;
    logic [2:0] f3;
    bit alt, ok;
    int alu;
    op  = {ins[6:2], 2'b11};
    f3  = ins[14:12];
    alt = ins[30];
    c   = mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
    case (op)
      7'h33, 7'h13: begin
        ok = 1; alu = 2;
        case (f3)
          3'd0: alu = (op == 7'h33 && alt) ? 6 : 2;
          3'd7: alu = 0;
          3'd6: alu = 1;
          3'd4: alu = 3;
          3'd2: alu = 7;
          3'd5: begin ok = !alt; alu = 5; end
          default: ok = 0;
        endcase
        if (ok) c = mk(0, (op == 7'h13) ? 1 : 0, 0, 0, 0, 1, 0, alu, 0, 0);
      end
      7'h03: c = mk(0, 1, 1, 0, 0, ready ? 1 : 0, 0, 2, 1, 0);
      7'h23: c = mk(1, 1, 0, 0, 0, 0, ready ? 1 : 0, 2, 1, 0);
      7'h63: if (f3 == 3'd0) c = mk(2, 0, 0, 0, 1, 0, 0, 6, 0, 0);
      7'h6F: c = mk(3, 0, 2, 1, 0, 1, 0, 0, 0, 0);
      default: ;
    endcase
    if (r) begin
      c.reg_write = 1'b0; c.mem_rw = 1'b0; c.mio = 1'b0;
    end
    c.stall = c.mio & ~ready;
    return c;
  endfunction

  task automatic drive(logic [31:0] ins, bit ready);
    cur_instr = ins;
    cur_ready = ready;
    OPcode    = ins[6:2];
    Fun3      = ins[14:12];
    Fun7      = ins[30];
    MIO_ready = ready;
  endtask

  // One rising edge with the watchdog model stepped alongside, then MIO_timeout checked.
  task automatic tick(string tag);
    ctl_t e;
    logic exp_to;
    @(posedge clk);
    e = model(cur_instr, cur_ready, rst);
    if (rst) begin
      m_cnt = 0; m_to = 0;
    end else if (e.stall) begin
      if (m_cnt < T) m_cnt++;
      if (m_cnt == T) m_to = 1;
    end else begin
      m_cnt = 0;
    end
    #1;
    exp_to = wd_en ? m_to : 1'b0;
    n_checks++;
    if (MIO_timeout !== exp_to) begin
      n_fails++;
      $display("FAIL %s: MIO_timeout got %b expected %b", tag, MIO_timeout, exp_to);
    end
  endtask

  task automatic test_reset();
    ctl_t got;
    rst = 1'b1;
    drive(32'h0040A283, 1'b0);
    tick("reset_timeout");
    got = observed();
    n_checks++;
    if (got !== mk(0, 1, 1, 0, 0, 0, 0, 2, 0, 0)) begin
      n_fails++;
      $display("FAIL reset_lw: got %h expected %h", got, mk(0, 1, 1, 0, 0, 0, 0, 2, 0, 0));
    end
    drive(32'h0050A423, 1'b1);
    #1;
    got = observed();
    n_checks++;
    if (got !== mk(1, 1, 0, 0, 0, 0, 0, 2, 0, 0)) begin
      n_fails++;
      $display("FAIL reset_sw: got %h expected %h", got, mk(1, 1, 0, 0, 0, 0, 0, 2, 0, 0));
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] ins [14];
    bit          rdy [14];
    ctl_t        exp [14];
    ctl_t        got;
    ins[0]  = 32'h002081B3; rdy[0]  = 1; exp[0]  = mk(0, 0, 0, 0, 0, 1, 0, 2, 0, 0);
    ins[1]  = 32'h402081B3; rdy[1]  = 1; exp[1]  = mk(0, 0, 0, 0, 0, 1, 0, 6, 0, 0);
    ins[2]  = 32'h0040A283; rdy[2]  = 1; exp[2]  = mk(0, 1, 1, 0, 0, 1, 0, 2, 1, 0);
    ins[3]  = 32'h0040A283; rdy[3]  = 0; exp[3]  = mk(0, 1, 1, 0, 0, 0, 0, 2, 1, 1);
    ins[4]  = 32'h0050A423; rdy[4]  = 1; exp[4]  = mk(1, 1, 0, 0, 0, 0, 1, 2, 1, 0);
    ins[5]  = 32'h0050A423; rdy[5]  = 0; exp[5]  = mk(1, 1, 0, 0, 0, 0, 0, 2, 1, 1);
    ins[6]  = 32'h00208463; rdy[6]  = 1; exp[6]  = mk(2, 0, 0, 0, 1, 0, 0, 6, 0, 0);
    ins[7]  = 32'h010000EF; rdy[7]  = 1; exp[7]  = mk(3, 0, 2, 1, 0, 1, 0, 0, 0, 0);
    ins[8]  = 32'h0000007F; rdy[8]  = 1; exp[8]  = mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
    ins[9]  = 32'h002091B3; rdy[9]  = 1; exp[9]  = mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
    ins[10] = 32'h00209463; rdy[10] = 1; exp[10] = mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
    ins[11] = 32'h40008093; rdy[11] = 1; exp[11] = mk(0, 1, 0, 0, 0, 1, 0, 2, 0, 0);
    ins[12] = 32'h4010D093; rdy[12] = 1; exp[12] = mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
    ins[13] = 32'h0040C093; rdy[13] = 0; exp[13] = mk(0, 1, 0, 0, 0, 1, 0, 3, 0, 0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(ins[i], rdy[i]);
      #1;
      got = observed();
      n_checks++;
      if (got !== exp[i]) begin
        n_fails++;
        $display("FAIL directed[%0d] instr %h ready %0d: got %h expected %h",
                 i, ins[i], rdy[i], got, exp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops [7];
    logic [31:0] ins;
    ctl_t        got, exp;
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23;
    ops[4] = 7'h63; ops[5] = 7'h6F; ops[6] = 7'h00;
    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 7) != 0)
        ins[6:0] = ops[$urandom_range(0, 5)];
      else
        ins[1:0] = 2'b11;
      @(negedge clk);
      drive(ins, ($urandom_range(0, 2) != 0));
      #1;
      got = observed();
      exp = model(ins, cur_ready, 1'b0);
      n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL random[%0d] instr %h ready %0d: got %h expected %h",
                 i, ins, cur_ready, got, exp);
      end
    end
  endtask

  task automatic test_watchdog();
    // Clean start
    @(negedge clk);
    rst = 1'b1;
    drive(32'h0040A283, 1'b0);
    tick("wd_reset");
    @(negedge clk);
    rst = 1'b0;
    // Held load: flag must rise on the 16th stalled edge and stick
    for (int i = 1; i <= T + 3; i++) tick($sformatf("wd_hold_edge%0d", i));
    n_checks++;
    if (MIO_timeout !== wd_en) begin
      n_fails++;
      $display("FAIL wd_after_hold: MIO_timeout got %b expected %b", MIO_timeout, wd_en);
    end
    @(negedge clk);
    drive(32'h0040A283, 1'b1);
    for (int i = 0; i < 4; i++) tick("wd_sticky_ready");
    @(negedge clk);
    drive(32'h002081B3, 1'b1);
    tick("wd_sticky_nonmem");
    @(negedge clk);
    rst = 1'b1;
    tick("wd_clear_rst");
    @(negedge clk);
    rst = 1'b0;
    // 15 waits then ready on the edge that would have hit the limit
    drive(32'h0050A423, 1'b0);
    for (int i = 0; i < T - 1; i++) tick("wd_15_waits");
    @(negedge clk);
    drive(32'h0050A423, 1'b1);
    for (int i = 0; i < 3; i++) tick("wd_ready_in_time");
    n_checks++;
    if (MIO_timeout !== 1'b0) begin
      n_fails++;
      $display("FAIL wd_no_timeout: MIO_timeout got %b expected 0", MIO_timeout);
    end
    // Reset mid-wait discards the partial count
    @(negedge clk);
    drive(32'h0040A283, 1'b0);
    for (int i = 0; i < 10; i++) tick("wd_pre_rst_wait");
    @(negedge clk);
    rst = 1'b1;
    tick("wd_mid_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < T + 2; i++) tick("wd_post_rst_wait");
  endtask

  initial begin
`ifdef CPU_CTRL_MIO_TIMEOUT_EN
    wd_en = 1'b1;
`else
    wd_en = 1'b0;
`endif
    m_cnt = 0;
    m_to  = 0;
    rst   = 1'b1;
    drive(32'h00000013, 1'b1);
    test_reset();
    test_directed();
    test_random();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
